// File: rtl/fwd_pkg.sv
// ============================================================================
// Module      : fwd_pkg
// Description : Shared types for the operand-forwarding / hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fwd_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10,
      FWD_WBBYP = 2'b11
   } fwd_sel_t;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
      logic                  is_load;
   } slot_t;

   // A slot only counts as a producer if it will actually write a real register.
   function automatic logic slot_produces(input slot_t s, input logic [REG_ADDR_W-1:0] zero_reg);
      return s.valid && s.we && (s.rd != zero_reg);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_hazard_unit_if.sv
// ============================================================================
// Module      : fwd_hazard_unit_if
// Description : ID-stage / hazard-unit signal bundle (master = ID stage).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fwd_hazard_unit_if #(
   parameter int REG_ADDR_W = fwd_pkg::REG_ADDR_W
);
   import fwd_pkg::*;

   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_we;
   logic                  id_is_load;
   logic                  flush;
   logic                  stall;
   fwd_sel_t              fwd_sel_a;
   fwd_sel_t              fwd_sel_b;
   logic                  ex_valid;

   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_we, id_is_load, flush,
      input  stall, fwd_sel_a, fwd_sel_b, ex_valid
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_we, id_is_load, flush,
      output stall, fwd_sel_a, fwd_sel_b, ex_valid
   );

endinterface

`default_nettype wire

// File: rtl/fwd_src_match.sv
// ============================================================================
// Module      : fwd_src_match
// Description : Matches one source specifier against the EX/MEM/WB slots.
//               FWD_WB_BYPASS_EN selects code 11 for a WB-slot hit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_src_match
   import fwd_pkg::*;
#(
   parameter int ZERO_REG = 0
) (
   input  wire logic [REG_ADDR_W-1:0] i_src,
   input  wire slot_t                 i_ex,
   input  wire slot_t                 i_mem,
   input  wire slot_t                 i_wb,
   output fwd_sel_t                   o_sel,
   output logic                       o_load_hit
);

   localparam logic [REG_ADDR_W-1:0] c_zero_reg = ZERO_REG[REG_ADDR_W-1:0];

   logic w_ex_hit;
   logic w_mem_hit;
   logic w_wb_hit;
   logic w_unused_is_load;

   assign w_ex_hit  = slot_produces(i_ex,  c_zero_reg) && (i_ex.rd  == i_src);
   assign w_mem_hit = slot_produces(i_mem, c_zero_reg) && (i_mem.rd == i_src);
   assign w_wb_hit  = slot_produces(i_wb,  c_zero_reg) && (i_wb.rd  == i_src);

   // Youngest producer wins.
   always_comb begin
      o_sel = FWD_RF;
      if (w_ex_hit) begin
         o_sel = FWD_EXMEM;
      end else if (w_mem_hit) begin
         o_sel = FWD_MEMWB;
      end else if (w_wb_hit) begin
`ifdef FWD_WB_BYPASS_EN
         o_sel = FWD_WBBYP;
`else
         o_sel = FWD_RF;
`endif
      end
   end

   assign o_load_hit       = w_ex_hit && i_ex.is_load;
   assign w_unused_is_load = i_mem.is_load ^ i_wb.is_load;

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// ============================================================================
// Module      : fwd_hazard_unit
// Description : EX operand-forward select generation and load-use stall.
//               Optional WB bypass code via FWD_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_unit #(
   parameter int REG_ADDR_W = fwd_pkg::REG_ADDR_W,
   parameter int ZERO_REG   = 0
) (
   input wire logic            clk,
   input wire logic            rst_n,
   fwd_hazard_unit_if.slave    bus
);
   import fwd_pkg::*;

   slot_t                 r_ex;
   slot_t                 r_mem;
   slot_t                 r_wb;
   fwd_sel_t              r_sel_a;
   fwd_sel_t              r_sel_b;
   fwd_sel_t              w_sel_a;
   fwd_sel_t              w_sel_b;
   logic                  w_hit_a;
   logic                  w_hit_b;
   logic                  w_stall;
   logic                  w_issue;
   logic [REG_ADDR_W-1:0] w_id_rd;

   assign w_id_rd = bus.id_rd;

   fwd_src_match #(.ZERO_REG(ZERO_REG)) u_match_a (
      .i_src      (bus.id_rs),
      .i_ex       (r_ex),
      .i_mem      (r_mem),
      .i_wb       (r_wb),
      .o_sel      (w_sel_a),
      .o_load_hit (w_hit_a)
   );

   fwd_src_match #(.ZERO_REG(ZERO_REG)) u_match_b (
      .i_src      (bus.id_rt),
      .i_ex       (r_ex),
      .i_mem      (r_mem),
      .i_wb       (r_wb),
      .o_sel      (w_sel_b),
      .o_load_hit (w_hit_b)
   );

   // Flush outranks the load-use stall; squashed instructions never stall.
   assign w_stall = bus.id_valid && !bus.flush && (w_hit_a || w_hit_b);
   assign w_issue = bus.id_valid && !w_stall && !bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex    <= '0;
         r_mem   <= '0;
         r_wb    <= '0;
         r_sel_a <= FWD_RF;
         r_sel_b <= FWD_RF;
      end else begin
         r_mem <= r_ex;
         r_wb  <= r_mem;
         if (w_issue) begin
            r_ex.valid   <= 1'b1;
            r_ex.rd      <= w_id_rd;
            r_ex.we      <= bus.id_we;
            r_ex.is_load <= bus.id_is_load;
            r_sel_a      <= w_sel_a;
            r_sel_b      <= w_sel_b;
         end else begin
            r_ex    <= '0;
            r_sel_a <= FWD_RF;
            r_sel_b <= FWD_RF;
         end
      end
   end

   assign bus.stall     = w_stall;
   assign bus.fwd_sel_a = r_sel_a;
   assign bus.fwd_sel_b = r_sel_b;
   assign bus.ex_valid  = r_ex.valid;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Directed scoreboard bench for fwd_hazard_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_unit;

`ifdef FWD_WB_BYPASS_EN
   localparam logic [1:0] c_wb = 2'b11;
`else
   localparam logic [1:0] c_wb = 2'b00;
`endif

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_fail;
   logic [3:0] sb_q[$];

   fwd_hazard_unit_if #(.REG_ADDR_W(5)) bus ();

   fwd_hazard_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   // One ID-stage cycle; expected selects are queued for instructions that issue.
   task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic we, input logic ld, input logic fl,
                       input logic exp_stall, input logic [1:0] exp_a, input logic [1:0] exp_b);
      @(negedge clk);
      bus.id_valid   = v;
      bus.id_rs      = rs;
      bus.id_rt      = rt;
      bus.id_rd      = rd;
      bus.id_we      = we;
      bus.id_is_load = ld;
      bus.flush      = fl;
      #1;
      check("stall", {3'b000, bus.stall}, {3'b000, exp_stall});
      if (v && !fl && !exp_stall) sb_q.push_back({exp_a, exp_b});
   endtask

   task automatic nop();
      step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
   endtask

   task automatic drain3();
      nop(); nop(); nop();
   endtask

   // Monitor: every real instruction reaching EX consumes one scoreboard entry.
   initial begin
      logic [3:0] exp;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && bus.ex_valid) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL ex_valid: got 1 expected 0 (no instruction due in EX) at %0t", $time);
            end else begin
               exp = sb_q.pop_front();
               check("fwd_sel_ab", {bus.fwd_sel_a, bus.fwd_sel_b}, exp);
            end
         end
      end
   end

   initial begin
      n_vec  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
      bus.id_we = 1'b0; bus.id_is_load = 1'b0; bus.flush = 1'b0;
      #1;
      check("reset_sel_a",    {2'b00, bus.fwd_sel_a}, 4'h0);
      check("reset_sel_b",    {2'b00, bus.fwd_sel_b}, 4'h0);
      check("reset_ex_valid", {3'b000, bus.ex_valid}, 4'h0);
      check("reset_stall",    {3'b000, bus.stall},    4'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // EX-slot forward on back-to-back dependency
      step(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00);
      step(1, 5'd3, 5'd4, 5'd6, 1, 0, 0, 0, 2'b01, 2'b00);
      drain3();
      // MEM-slot forward with one gap
      step(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00);
      nop();
      step(1, 5'd4, 5'd3, 5'd9, 1, 0, 0, 0, 2'b00, 2'b10);
      drain3();
      // WB-slot hit with two gaps
      step(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00);
      nop(); nop();
      step(1, 5'd4, 5'd3, 5'd9, 1, 0, 0, 0, 2'b00, c_wb);
      drain3();
      // Two producers of r10, rs == rt: youngest wins
      step(1, 5'd1,  5'd2,  5'd10, 1, 0, 0, 0, 2'b00, 2'b00);
      step(1, 5'd10, 5'd10, 5'd10, 1, 0, 0, 0, 2'b01, 2'b01);
      nop();
      step(1, 5'd10, 5'd10, 5'd11, 1, 0, 0, 0, 2'b10, 2'b10);
      drain3();
      // Non-writing instruction is not a producer
      step(1, 5'd1,  5'd2,  5'd12, 0, 0, 0, 0, 2'b00, 2'b00);
      step(1, 5'd12, 5'd12, 5'd13, 0, 0, 0, 0, 2'b00, 2'b00);
      // Load in EX but ID holds no instruction: no stall
      step(1, 5'd1, 5'd2, 5'd5, 1, 1, 0, 0, 2'b00, 2'b00);
      step(0, 5'd5, 5'd5, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00);
      drain3();
      // Load-use: one stall cycle then MEM forward
      step(1, 5'd1, 5'd0, 5'd5, 1, 1, 0, 0, 2'b00, 2'b00);
      step(1, 5'd5, 5'd6, 5'd7, 1, 0, 0, 1, 2'b00, 2'b00);
      step(1, 5'd5, 5'd6, 5'd7, 1, 0, 0, 0, 2'b10, 2'b00);
      drain3();
      // Load-use with flush: no stall, consumer squashed
      step(1, 5'd1, 5'd2, 5'd5, 1, 1, 0, 0, 2'b00, 2'b00);
      step(1, 5'd6, 5'd5, 5'd7, 1, 0, 1, 0, 2'b00, 2'b00);
      drain3();
      // r0 producer (even a load) never forwards or stalls
      step(1, 5'd1, 5'd2, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00);
      step(1, 5'd0, 5'd0, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00);
      nop();
      step(1, 5'd0, 5'd0, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00);
      drain3();
      // Reset asserted between clock edges while stalled
      step(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00);
      step(1, 5'd3, 5'd0, 5'd5, 1, 1, 0, 0, 2'b01, 2'b00);
      step(1, 5'd5, 5'd5, 5'd6, 1, 0, 0, 1, 2'b00, 2'b00);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_stall",    {3'b000, bus.stall},    4'h0);
      check("midrst_sel_a",    {2'b00, bus.fwd_sel_a}, 4'h0);
      check("midrst_sel_b",    {2'b00, bus.fwd_sel_b}, 4'h0);
      check("midrst_ex_valid", {3'b000, bus.ex_valid}, 4'h0);
      @(negedge clk);
      bus.id_valid = 1'b0;
      rst_n = 1'b1;
      step(1, 5'd5, 5'd5, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00);
      drain3();
      @(negedge clk);

      n_vec++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending instructions expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
